// File: rtl/matrizpuntos_scan_ctrl.sv
// Row-scan controller for an 8x16 multiplexed LED dot matrix: double-buffered frame, blanking, PWM.
// Optional PWM brightness gating is enabled by defining MATRIZPUNTOS_SCAN_PWM_EN.
module matrizpuntos_scan_ctrl #(
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          enable,
  input  logic [127:0]  frame_data,
  input  logic          frame_valid,
  output logic          frame_ready,
  input  logic [3:0]    brightness,
  output logic [7:0]    row_n,
  output logic [15:0]   col,
  output logic          frame_done,
  output logic          busy
);

  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      row_reg, row_next;
  logic [DW-1:0]   dwell_cnt_reg, dwell_cnt_next;
  logic [BW-1:0]   blank_cnt_reg, blank_cnt_next;
  logic [127:0]    pending_reg, pending_next;
  logic [127:0]    active_reg, active_next;
  logic            pending_full_reg, pending_full_next;
  logic [7:0]      row_n_reg, row_n_next;
  logic [15:0]     col_reg, col_next;
  logic            frame_done_reg, frame_done_next;
  logic            busy_reg, busy_next;
  logic            wrap, frame_start, accept, copy, pix_on;
  logic [15:0]     row_bits;

`ifdef MATRIZPUNTOS_SCAN_PWM_EN
  logic [3:0]      phase_reg, phase_next;
  logic [3:0]      bright_reg, bright_next;
`else
  logic            unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // Scan sequencing; enable low overrides every state.
  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    dwell_cnt_next = dwell_cnt_reg;
    blank_cnt_next = blank_cnt_reg;
    wrap           = 1'b0;
    frame_start    = 1'b0;
    if (!enable) begin
      state_next     = IDLE;
      row_next       = '0;
      dwell_cnt_next = '0;
      blank_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = BLANK;
          row_next       = '0;
          blank_cnt_next = '0;
          frame_start    = 1'b1;
        end
        BLANK: begin
          if (blank_cnt_reg == BLANK_LAST) begin
            state_next     = DWELL;
            dwell_cnt_next = '0;
          end else begin
            blank_cnt_next = blank_cnt_reg + 1'b1;
          end
        end
        DWELL: begin
          if (dwell_cnt_reg == DWELL_LAST) begin
            state_next     = BLANK;
            blank_cnt_next = '0;
            row_next       = row_reg + 3'd1;
            wrap           = (row_reg == 3'd7);
          end else begin
            dwell_cnt_next = dwell_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Buffers and output values, computed from next state so outputs align with it.
  always_comb begin
    accept            = frame_valid && !pending_full_reg;
    copy              = pending_full_reg && (wrap || (state_reg == IDLE));
    pending_next      = accept ? frame_data : pending_reg;
    pending_full_next = accept | (pending_full_reg & ~copy);
    active_next       = copy ? pending_reg : active_reg;
    row_bits          = active_next[{row_next, 4'b0000} +: 16];
`ifdef MATRIZPUNTOS_SCAN_PWM_EN
    bright_next = (frame_start || wrap) ? brightness : bright_reg;
    phase_next  = ((state_reg == DWELL) && (state_next == DWELL)) ? phase_reg + 4'd1 : 4'd0;
    pix_on      = (phase_next < bright_next);
`else
    pix_on      = 1'b1;
`endif
    row_n_next = 8'hFF;
    col_next   = '0;
    if (state_next == DWELL) begin
      row_n_next = ~(8'd1 << row_next);
      if (pix_on) col_next = row_bits;
    end
    frame_done_next = wrap;
    busy_next       = (state_next != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg        <= IDLE;
      row_reg          <= '0;
      dwell_cnt_reg    <= '0;
      blank_cnt_reg    <= '0;
      pending_reg      <= '0;
      active_reg       <= '0;
      pending_full_reg <= 1'b0;
      row_n_reg        <= 8'hFF;
      col_reg          <= '0;
      frame_done_reg   <= 1'b0;
      busy_reg         <= 1'b0;
`ifdef MATRIZPUNTOS_SCAN_PWM_EN
      phase_reg        <= '0;
      bright_reg       <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      row_reg          <= row_next;
      dwell_cnt_reg    <= dwell_cnt_next;
      blank_cnt_reg    <= blank_cnt_next;
      pending_reg      <= pending_next;
      active_reg       <= active_next;
      pending_full_reg <= pending_full_next;
      row_n_reg        <= row_n_next;
      col_reg          <= col_next;
      frame_done_reg   <= frame_done_next;
      busy_reg         <= busy_next;
`ifdef MATRIZPUNTOS_SCAN_PWM_EN
      phase_reg        <= phase_next;
      bright_reg       <= bright_next;
`endif
    end
  end

  assign frame_ready = ~pending_full_reg;
  assign row_n       = row_n_reg;
  assign col         = col_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;

endmodule
